// File: rtl/pc_gen_pkg.sv
// Shared constants for the instruction-fetch program-counter generator.
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;

    localparam int unsigned AddrWDef   = 32;
    localparam int unsigned StallWDef  = 6;
    localparam int unsigned StallPcBit = 0;

endpackage

// File: rtl/pc_br_buffer.sv
// One-entry pending-branch register: holds a branch target that arrived while the PC stage stalled.
module pc_br_buffer
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              release_i,
    input  logic              clear_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] target_o
);

    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] target_d, target_q;

    // Clear beats capture beats release; a newer capture simply overwrites.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (clear_i) begin
            valid_d  = 1'b0;
            target_d = '0;
        end else if (capture_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end else if (release_i) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: reset vector, stall, flush redirect, pending branch and
// misaligned-target detection for the fetch stage.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = AddrWDef,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int unsigned       INST_BYTES = 4,
    parameter int unsigned       STALL_W    = StallWDef
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               br_pending_o,
    output logic               misalign_o
);

    localparam logic [ADDR_W-1:0] Incr      = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] AlignMask = ~(Incr - 1'b1);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              ce_d, ce_q;
    logic              misalign_d, misalign_q;

    logic              buf_capture, buf_release, buf_clear, buf_valid;
    logic [ADDR_W-1:0] buf_target;
    logic              load_en;
    logic [ADDR_W-1:0] load_target;
    logic              stall_pc;

    // Only the PC-stage bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^stall;
    assign stall_pc     = stall[StallPcBit];

    pc_br_buffer #(
        .ADDR_W (ADDR_W)
    ) u_br_buffer (
        .clk       (clk),
        .rst       (rst),
        .capture_i (buf_capture),
        .target_i  (branch_target_address_i),
        .release_i (buf_release),
        .clear_i   (buf_clear),
        .valid_o   (buf_valid),
        .target_o  (buf_target)
    );

    always_comb begin
        ce_d        = (rst == RstEnable) ? ChipDisable : ChipEnable;
        pc_d        = pc_q;
        misalign_d  = 1'b0;
        buf_capture = 1'b0;
        buf_release = 1'b0;
        buf_clear   = 1'b0;
        load_en     = 1'b0;
        load_target = '0;

        if (rst == RstEnable || ce_q == ChipDisable) begin
            pc_d      = RESET_VEC;
            buf_clear = 1'b1;
        end else if (flush_i) begin
            load_en     = 1'b1;
            load_target = new_pc_i;
            buf_clear   = 1'b1;
        end else if (stall_pc) begin
            buf_capture = (branch_flag_i == Branch);
        end else if (buf_valid) begin
            // ID is invalid behind a redirect, so a concurrent branch is dropped.
            load_en     = 1'b1;
            load_target = buf_target;
            buf_release = 1'b1;
        end else if (branch_flag_i == Branch) begin
            load_en     = 1'b1;
            load_target = branch_target_address_i;
        end else begin
            pc_d = pc_q + Incr;
        end

        if (load_en) begin
            pc_d       = load_target & AlignMask;
            misalign_d = |(load_target & ~AlignMask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q       <= RESET_VEC;
            ce_q       <= ChipDisable;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign ce           = ce_q;
    assign br_pending_o = buf_valid;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: vector table through a scoreboard queue, plus a 16-bit wrap sequence.
module tb_pc_gen;

    typedef struct {
        logic        rst;
        logic        stall0;
        logic        br;
        logic [31:0] bt;
        logic        fl;
        logic [31:0] np;
        logic [31:0] e_pc;
        logic        e_ce;
        logic        e_pend;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic [31:0] pc;
    logic        ce, br_pending, misalign;

    logic [15:0] pc16;
    logic        ce16, pend16, mis16;

    int errors = 0;
    int checks = 0;
    exp_t sb_q[$];
    vec_t vecs[32];

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W     (32),
        .RESET_VEC  (32'hBFC0_0000),
        .INST_BYTES (4),
        .STALL_W    (6)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag),
        .branch_target_address_i (branch_target),
        .flush_i                 (flush),
        .new_pc_i                (new_pc),
        .pc                      (pc),
        .ce                      (ce),
        .br_pending_o            (br_pending),
        .misalign_o              (misalign)
    );

    pc_gen #(
        .ADDR_W     (16),
        .RESET_VEC  (16'hFFF8),
        .INST_BYTES (4),
        .STALL_W    (6)
    ) dut16 (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (6'b0),
        .branch_flag_i           (1'b0),
        .branch_target_address_i (16'h0),
        .flush_i                 (1'b0),
        .new_pc_i                (16'h0),
        .pc                      (pc16),
        .ce                      (ce16),
        .br_pending_o            (pend16),
        .misalign_o              (mis16)
    );

    function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] t, logic f,
                                logic [31:0] n, logic [31:0] epc, logic ece, logic ep,
                                logic em);
        vec_t v;
        v.rst = r; v.stall0 = s; v.br = b; v.bt = t; v.fl = f; v.np = n;
        v.e_pc = epc; v.e_ce = ece; v.e_pend = ep; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rst           = v.rst;
        stall         = {5'b0, v.stall0};
        branch_flag   = v.br;
        branch_target = v.bt;
        flush         = v.fl;
        new_pc        = v.np;
        e.pc = v.e_pc; e.ce = v.e_ce; e.pend = v.e_pend; e.mis = v.e_mis;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d pc", idx), pc, e.pc);
        chk($sformatf("v%0d ce", idx), {31'b0, ce}, {31'b0, e.ce});
        chk($sformatf("v%0d br_pending", idx), {31'b0, br_pending}, {31'b0, e.pend});
        chk($sformatf("v%0d misalign", idx), {31'b0, misalign}, {31'b0, e.mis});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst s  br bt            fl np            exp_pc        ce p  m
        vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00004, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00008, 1, 0, 0);
        vecs[6]  = mk(0, 0, 1, 32'h000000FC, 0, 32'h0,        32'h000000FC, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000100, 1, 0, 0);
        vecs[8]  = mk(0, 1, 1, 32'h00000200, 0, 32'h0,        32'h00000100, 1, 1, 0);
        vecs[9]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h00000100, 1, 1, 0);
        vecs[10] = mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h00000100, 1, 1, 0);
        vecs[11] = mk(0, 0, 1, 32'h00000300, 0, 32'h0,        32'h00000200, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000204, 1, 0, 0);
        vecs[13] = mk(0, 1, 1, 32'h00000200, 0, 32'h0,        32'h00000204, 1, 1, 0);
        vecs[14] = mk(0, 1, 0, 32'h0,        1, 32'h00000380, 32'h00000380, 1, 0, 0);
        vecs[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000384, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000388, 1, 0, 0);
        vecs[17] = mk(0, 0, 1, 32'h00000107, 0, 32'h0,        32'h00000104, 1, 0, 1);
        vecs[18] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000108, 1, 0, 0);
        vecs[19] = mk(0, 1, 1, 32'h0000020A, 0, 32'h0,        32'h00000108, 1, 1, 0);
        vecs[20] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000208, 1, 0, 1);
        vecs[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000020C, 1, 0, 0);
        vecs[22] = mk(0, 0, 0, 32'h0,        1, 32'h00000401, 32'h00000400, 1, 0, 1);
        vecs[23] = mk(0, 0, 1, 32'h00000600, 1, 32'h00000500, 32'h00000500, 1, 0, 0);
        vecs[24] = mk(0, 1, 1, 32'h00000700, 0, 32'h0,        32'h00000500, 1, 1, 0);
        vecs[25] = mk(0, 1, 1, 32'h00000800, 0, 32'h0,        32'h00000500, 1, 1, 0);
        vecs[26] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000800, 1, 0, 0);
        vecs[27] = mk(0, 1, 1, 32'h00000900, 0, 32'h0,        32'h00000800, 1, 1, 0);
        vecs[28] = mk(1, 0, 0, 32'h0,        1, 32'h00000380, 32'hBFC00000, 0, 0, 0);
        vecs[29] = mk(0, 0, 0, 32'h0,        1, 32'h00000ABC, 32'hBFC00000, 1, 0, 0);
        vecs[30] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00004, 1, 0, 0);
        vecs[31] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00008, 1, 0, 0);

        for (int i = 0; i < 32; i++) begin
            apply(vecs[i], i);
        end

        // 16-bit instance: reset to FFF8 and let it wrap past the top of the address space.
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("w16 reset ce", {31'b0, ce16}, 32'd0);
        chk("w16 reset pc", {16'b0, pc16}, 32'h0000FFF8);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] exp16;
            case (k)
                0:       exp16 = 16'hFFF8;
                1:       exp16 = 16'hFFFC;
                2:       exp16 = 16'h0000;
                default: exp16 = 16'h0004;
            endcase
            @(posedge clk);
            #1;
            chk($sformatf("w16 step%0d pc", k), {16'b0, pc16}, {16'b0, exp16});
            chk($sformatf("w16 step%0d ce", k), {31'b0, ce16}, 32'd1);
            chk($sformatf("w16 step%0d misalign", k), {31'b0, mis16}, 32'd0);
            chk($sformatf("w16 step%0d pending", k), {31'b0, pend16}, 32'd0);
        end

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
